// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the counter-FIFO drain reader.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int OUT_BUF_DEPTH = 3;

endpackage

// File: rtl/fifo_drain_outbuf.sv
// Three-entry circular output buffer that holds records between the FIFO read and the stream handoff.
module fifo_drain_outbuf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam logic [1:0] DEPTH_L = 2'(OUT_BUF_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [OUT_BUF_DEPTH];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_occ;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == DEPTH_L - 2'd1) ? 2'd0 : p + 2'd1;
  endfunction

  // A push is accepted when full only if a pop frees a slot in the same cycle.
  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != DEPTH_L) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_occ    <= 2'd0;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_drain_reader.sv
// Dequeues records from the counter FIFO, absorbs its one-cycle read latency and re-presents them
// on a valid/ready stream (beat moves when m_valid && m_ready); a drain tags the final record with m_last.
module fifo_drain_reader
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   drain_req,
  output logic                   drain_done,
  input  logic                   fifo_empty,
  output logic                   fifo_dequeue,
  input  logic [DATA_WIDTH-1:0]  fifo_front,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [COUNT_WIDTH-1:0] drained_count
);

  state_t                 r_state;
  logic                   r_inflight;
  logic                   r_last_hold;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [1:0]             w_occ;
  logic [DATA_WIDTH-1:0]  w_head;
  logic                   w_hs;
  logic                   w_last;
  logic                   w_allow;
  logic                   w_credit;
  logic                   w_drain_empty;

  fifo_drain_outbuf #(.DATA_WIDTH(DATA_WIDTH)) u_outbuf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (fifo_front),
    .i_pop       (w_hs),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  // Once the last beat is flagged it is held, so a late upstream enqueue cannot retract it.
  assign w_last        = (r_state == DRAIN) &&
                         (r_last_hold || ((w_occ == 2'd1) && !r_inflight && fifo_empty));
  assign w_drain_empty = (w_occ == 2'd0) && !r_inflight && fifo_empty;
  assign w_allow       = (r_state == RUN) || ((r_state == DRAIN) && !w_last);
  assign w_credit      = ({1'b0, w_occ} + {2'b0, r_inflight}) < 3'(OUT_BUF_DEPTH);
  assign fifo_dequeue  = w_allow && !fifo_empty && w_credit;

  assign m_valid       = (w_occ != 2'd0);
  assign m_data        = w_head;
  assign m_last        = w_last;
  assign w_hs          = m_valid && m_ready;
  assign drain_done    = (r_state == DONE);
  assign drained_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_inflight  <= 1'b0;
      r_last_hold <= 1'b0;
      r_count     <= '0;
    end else begin
      r_inflight  <= fifo_dequeue;
      r_last_hold <= 1'b0;
      if (w_hs && (r_count != {COUNT_WIDTH{1'b1}})) r_count <= r_count + 1'b1;
      case (r_state)
        IDLE: begin
          if (drain_req)   r_state <= DRAIN;
          else if (enable) r_state <= RUN;
        end
        RUN: begin
          if (drain_req)    r_state <= DRAIN;
          else if (!enable) r_state <= IDLE;
        end
        DRAIN: begin
          if (w_hs && w_last)     r_state <= DONE;
          else if (w_drain_empty) r_state <= DONE;
          else                    r_last_hold <= w_last;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
